// File: rtl/multiplier_seq_pkg.sv
// Shared encodings for the sequential arithmetic blocks (state codes used by
// multiplier_seq and its siblings).
package multiplier_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/adder_nbit.sv
// Ripple-carry n-bit adder with carry-in tied low; IMPL_TYPE selects the
// full-adder cell carry formulation (0: generate/propagate, 1: majority).
module adder_nbit #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum
);

  logic [WIDTH-1:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_p;
    assign w_p    = A[i] ^ B[i];
    assign Sum[i] = w_p ^ w_carry[i];
    // The carry out of the top cell lands in the caller's extra Sum bit, so it
    // is never generated here.
    if (i < WIDTH - 1) begin : g_carry
      if (IMPL_TYPE == 0) begin : g_gp
        assign w_carry[i+1] = (A[i] & B[i]) | (w_p & w_carry[i]);
      end else begin : g_maj
        assign w_carry[i+1] = (A[i] & B[i]) | (A[i] & w_carry[i]) | (B[i] & w_carry[i]);
      end
    end
  end

endmodule

// File: rtl/multiplier_seq.sv
// Unsigned shift-and-add multiplier: one partial-product add per clock,
// WIDTH add/shift cycles per operation, valid/ready on both sides.
module multiplier_seq
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_sum;

  // Widened by one bit so the accumulator carry is kept and shifted back in.
  adder_nbit #(
    .WIDTH     (WIDTH + 1),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_acc_add (
    .A   ({1'b0, r_hi}),
    .B   ({1'b0, r_mcand}),
    .Sum (w_sum)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign Product   = {r_hi, r_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_lo    <= B;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_lo[0]) begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= {1'b0, r_hi[WIDTH-1:1]};
            r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Multiplicand is pure data; it only needs to be valid once an operation starts.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && in_valid) begin
      r_mcand <= A;
    end
  end

endmodule

// File: doc/multiplier_seq.md
Name: multiplier_seq

Overview:
- Unsigned sequential shift-and-add multiplier; one partial-product add per clock.
- Direct consumer/driver of the team's ripple-carry n-bit adder: instantiates it once, WIDTH+1 bits wide, as the accumulator adder.
- Feeds the mantissa-product path of the FP multiply datapath.
- Valid/ready handshakes on input and output; one operation in flight.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64.
- IMPL_TYPE, 0, passed unchanged to the adder's IMPL_TYPE (full-adder cell implementation select).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  multiplicand, unsigned.
- B  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  Product valid.
- out_ready  input  1  consumer accepts Product.
- Product  output  2*WIDTH  A*B, unsigned, exact.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; in_ready=1 in the following cycle; out_valid=0; Product=0.
  - Accumulator, multiplier shift register and counter are cleared.
  - Takes effect in any state; an operation in progress is discarded with no output.
- States are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1 (combinational decode of state only, not of in_valid).
  - On in_valid&&in_ready at an edge: latch A into mcand; load lo=B, hi=0, cnt=0; go to CALC.
- CALC:
  - in_ready=0; out_valid=0.
  - Each cycle, the adder computes {1'b0,hi}+{1'b0,mcand}, WIDTH+1 bits; Sum[WIDTH] is the carry.
  - If lo[0]=1, the next {hi,lo} is {Sum,lo}>>1. Otherwise it is {1'b0,hi,lo}>>1.
  - cnt increments. When cnt==WIDTH-1 at an edge, go to DONE after that shift.
  - Exactly WIDTH CALC cycles.
- DONE:
  - out_valid=1; Product={hi,lo}.
  - Product is held stable while out_ready=0 (no limit on back-pressure).
  - On out_valid&&out_ready at an edge: go to IDLE; out_valid drops next cycle. Product keeps its value until the next load.
- Latency:
  - Accept edge k; out_valid is high from the cycle after edge k+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles.
- in_valid while in_ready=0 is ignored; the upstream must hold operands.
- A and B may change freely after the accept edge.
- Width rules:
  - No overflow is possible; 2*WIDTH bits always hold the product.
  - The adder carry is never dropped.
  - cnt is $clog2(WIDTH) bits wide and never wraps before DONE.
- Operand edge cases:
  - A=0 or B=0 still takes the full WIDTH cycles; Product=0.
  - No early termination.
- out_ready asserted outside DONE has no effect.

Decomposition:
- State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) go in the shared arithmetic defines header, so all sequential arith blocks share them.
- Sub-module: adder_nbit, instantiated once with WIDTH=WIDTH+1 and IMPL_TYPE forwarded.
- No other sub-modules; control FSM and shift register stay in multiplier_seq.

Test Plan:
- WIDTH=8, A=13, B=11, out_ready=1 -> Product=143 (16'h008F).
  - out_valid rises exactly 9 cycles after the accept cycle.
  - in_ready returns to 1 one cycle after the output handshake.
- WIDTH=8, A=255, B=255 -> Product=65025 (16'hFE01); checks adder carry into bit 8.
- WIDTH=8, A=0, B=200, then A=200, B=0 -> Product=0 both times, each after the full 8 CALC cycles.
- WIDTH=8, A=7, B=9, out_ready=0 for 20 cycles after out_valid -> Product holds 63 and out_valid stays 1.
  - in_valid pulses with A=1, B=1 during CALC/DONE are ignored.
  - out_ready=1 completes the transfer; the next result is from a freshly accepted operand pair only.
- WIDTH=8, A=100, B=50, rst=1 for one cycle at CALC cycle 4:
  - Next cycle: state IDLE, in_ready=1, out_valid=0, Product=0; no result is emitted.
  - A subsequent 3*5 returns 15.
- WIDTH=32, IMPL_TYPE=0 and 1, 1000 random A/B pairs with random out_ready back-pressure -> Product == A*B (64-bit reference) for every pair, in order, none lost or duplicated.
